// File: rtl/instr_encoder.sv
// Instruction encoder: captures a request, validates its op_code, packs it into a
// 32-bit word and writes it to sequential instruction-memory addresses until full.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op_type,
  input  logic [3:0]        op_code,
  input  logic [3:0]        rd,
  input  logic [3:0]        rs1,
  input  logic [3:0]        rs2,
  input  logic [17:0]       imm,
  input  logic              clear,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic              full
);

  typedef enum logic [1:0] {IDLE, ENC, WRITE, FULL} stateT;

  localparam logic [ADDR_W-1:0] lastAddr = {ADDR_W{1'b1}};

  stateT        state, nextState;
  logic [1:0]   opTypeQ;
  logic [3:0]   opCodeQ, rdQ, rs1Q, rs2Q;
  logic [17:0]  immQ;
  logic [31:0]  wordReg;
  logic [ADDR_W-1:0] wrPtr;
  logic [7:0]   errCnt;
  logic         legal;
  logic [31:0]  encWord;

  // Legality and encoding are derived only from the captured copy of the request.
  always_comb begin
    legal = 1'b0;
    case (opTypeQ)
      2'b00:   legal = (opCodeQ[2:0] <= 3'd5);
      2'b01:   legal = (opCodeQ <= 4'd5);
      default: legal = (opCodeQ <= 4'd3);
    endcase
  end

  always_comb begin
    encWord = {opTypeQ, opCodeQ, rdQ, rs1Q, 18'd0};
    if (opTypeQ[0])
      encWord[17:0] = immQ;
    else
      encWord[17:14] = rs2Q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (clear) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) nextState = ENC;
        ENC:     nextState = legal ? WRITE : IDLE;
        WRITE:   nextState = (wrPtr == lastAddr) ? FULL : IDLE;
        default: nextState = FULL;
      endcase
    end
  end

  // Capture, word register, write pointer and saturating error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opTypeQ <= '0;
      opCodeQ <= '0;
      rdQ     <= '0;
      rs1Q    <= '0;
      rs2Q    <= '0;
      immQ    <= '0;
      wordReg <= '0;
      wrPtr   <= '0;
      errCnt  <= '0;
    end else if (clear) begin
      wrPtr  <= '0;
      errCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opTypeQ <= op_type;
            opCodeQ <= op_code;
            rdQ     <= rd;
            rs1Q    <= rs1;
            rs2Q    <= rs2;
            immQ    <= imm;
          end
        end
        ENC: begin
          if (legal)
            wordReg <= encWord;
          else if (errCnt != 8'hFF)
            errCnt <= errCnt + 8'd1;
        end
        WRITE: begin
          if (wrPtr != lastAddr)
            wrPtr <= wrPtr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // The write strobe is dropped in any cycle clear is high so a pending write aborts.
  assign imem_we    = (state == WRITE) && !clear;
  assign imem_addr  = wrPtr;
  assign imem_wdata = wordReg;
  assign err        = (state == ENC) && !legal;
  assign err_cnt    = errCnt;
  assign full       = (state == FULL);
  assign in_ready   = (state == IDLE);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (ADDR_W=2): table of requests with hand-computed
// words, plus sequences for full/clear, clear-during-write, reset-during-write, saturation.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op_type;
  logic [3:0]  op_code, rd, rs1, rs2;
  logic [17:0] imm;
  logic        clear;
  logic        imem_we;
  logic [1:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        err;
  logic [7:0]  err_cnt;
  logic        full;

  int checks = 0;
  int fails  = 0;
  int expPtr = 0;
  int expErr = 0;

  typedef struct {
    logic [1:0]  opType;
    logic [3:0]  opCode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [17:0] imm;
    logic        legal;
    logic [31:0] word;
  } vecT;

  vecT tbl[11];

  instr_encoder #(.ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_type(op_type), .op_code(op_code), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .clear(clear), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .err(err), .err_cnt(err_cnt), .full(full)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic driveReq(input vecT v, input logic valid);
    in_valid = valid;
    op_type  = v.opType;
    op_code  = v.opCode;
    rd       = v.rd;
    rs1      = v.rs1;
    rs2      = v.rs2;
    imm      = v.imm;
  endtask

  task automatic scramble();
    in_valid = 1'b0;
    op_type  = 2'($urandom);
    op_code  = 4'($urandom);
    rd       = 4'($urandom);
    rs1      = 4'($urandom);
    rs2      = 4'($urandom);
    imm      = 18'($urandom);
  endtask

  // One request from IDLE to back in IDLE (or FULL), checking every cycle.
  task automatic applyStimulus(input vecT v);
    @(negedge clk);
    checkOutput("idle in_ready", 32'(in_ready), 32'd1);
    checkOutput("idle imem_addr", 32'(imem_addr), 32'(expPtr));
    driveReq(v, 1'b1);
    @(negedge clk);
    scramble();
    checkOutput("enc err", 32'(err), 32'(!v.legal));
    checkOutput("enc imem_we", 32'(imem_we), 32'd0);
    checkOutput("enc in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    if (v.legal) begin
      checkOutput("write imem_we", 32'(imem_we), 32'd1);
      checkOutput("write imem_addr", 32'(imem_addr), 32'(expPtr));
      checkOutput("write imem_wdata", imem_wdata, v.word);
      @(negedge clk);
      checkOutput("post imem_we", 32'(imem_we), 32'd0);
      if (expPtr == 3) begin
        checkOutput("full flag", 32'(full), 32'd1);
        checkOutput("full in_ready", 32'(in_ready), 32'd0);
        checkOutput("full imem_addr", 32'(imem_addr), 32'd3);
      end else begin
        expPtr++;
        checkOutput("post in_ready", 32'(in_ready), 32'd1);
        checkOutput("post imem_addr", 32'(imem_addr), 32'(expPtr));
      end
    end else begin
      if (expErr < 255) expErr++;
      checkOutput("illegal err drop", 32'(err), 32'd0);
      checkOutput("illegal imem_we", 32'(imem_we), 32'd0);
      checkOutput("illegal in_ready", 32'(in_ready), 32'd1);
      checkOutput("illegal err_cnt", 32'(err_cnt), 32'(expErr));
    end
  endtask

  initial begin
    tbl[0]  = '{2'b00, 4'b0000, 4'd3,  4'd1,  4'd2,  18'h3ABCD, 1'b1, 32'h00C48000};
    tbl[1]  = '{2'b01, 4'b0010, 4'd5,  4'd4,  4'd9,  18'h00007, 1'b1, 32'h49500007};
    tbl[2]  = '{2'b10, 4'b0100, 4'd1,  4'd1,  4'd1,  18'h00000, 1'b0, 32'h0};
    tbl[3]  = '{2'b00, 4'b1101, 4'd0,  4'd15, 4'd15, 18'h00000, 1'b1, 32'h343FC000};
    tbl[4]  = '{2'b00, 4'b0110, 4'd2,  4'd2,  4'd2,  18'h00000, 1'b0, 32'h0};
    tbl[5]  = '{2'b01, 4'b0110, 4'd2,  4'd2,  4'd2,  18'h00001, 1'b0, 32'h0};
    tbl[6]  = '{2'b01, 4'b1000, 4'd2,  4'd2,  4'd2,  18'h00001, 1'b0, 32'h0};
    tbl[7]  = '{2'b11, 4'b0011, 4'd15, 4'd0,  4'd5,  18'h3FFFF, 1'b1, 32'hCFC3FFFF};
    tbl[8]  = '{2'b11, 4'b0100, 4'd1,  4'd1,  4'd1,  18'h00010, 1'b0, 32'h0};
    tbl[9]  = '{2'b10, 4'b0011, 4'd2,  4'd3,  4'd4,  18'h12345, 1'b1, 32'h8C8D0000};
    tbl[10] = '{2'b01, 4'b0101, 4'd1,  4'd2,  4'd7,  18'h20000, 1'b1, 32'h544A0000};

    rst = 1'b1;
    clear = 1'b0;
    scramble();
    #1;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset imem_we", 32'(imem_we), 32'd0);
    checkOutput("reset imem_wdata", imem_wdata, 32'd0);
    checkOutput("reset imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("reset err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("reset err/full", {30'd0, err, full}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i]);
      if (full) begin
        // Requests in FULL must be ignored until clear.
        driveReq(tbl[0], 1'b1);
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          checkOutput("full ignores imem_we", 32'(imem_we), 32'd0);
          checkOutput("full holds", {30'd0, full, in_ready}, 32'd2);
        end
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        expPtr = 0;
        expErr = 0;
        checkOutput("clear full", 32'(full), 32'd0);
        checkOutput("clear in_ready", 32'(in_ready), 32'd1);
        checkOutput("clear imem_addr", 32'(imem_addr), 32'd0);
        checkOutput("clear err_cnt", 32'(err_cnt), 32'd0);
      end
    end

    // Clear during WRITE aborts the strobe and restarts the pointer.
    @(negedge clk);
    driveReq(tbl[1], 1'b1);
    @(negedge clk);
    scramble();
    @(negedge clk);
    checkOutput("pre-clear imem_we", 32'(imem_we), 32'd1);
    checkOutput("pre-clear imem_addr", 32'(imem_addr), 32'(expPtr));
    clear = 1'b1;
    #1;
    checkOutput("clear gates imem_we", 32'(imem_we), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    expPtr = 0;
    expErr = 0;
    checkOutput("after clear in_ready", 32'(in_ready), 32'd1);
    checkOutput("after clear imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("after clear err_cnt", 32'(err_cnt), 32'd0);

    // Reset during WRITE drops everything asynchronously.
    applyStimulus(tbl[2]);
    applyStimulus(tbl[0]);
    @(negedge clk);
    driveReq(tbl[7], 1'b1);
    @(negedge clk);
    scramble();
    @(negedge clk);
    checkOutput("pre-reset imem_we", 32'(imem_we), 32'd1);
    checkOutput("pre-reset imem_addr", 32'(imem_addr), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset imem_we", 32'(imem_we), 32'd0);
    checkOutput("async reset imem_wdata", imem_wdata, 32'd0);
    checkOutput("async reset imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("async reset err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("async reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    expPtr = 0;
    expErr = 0;
    @(negedge clk);
    checkOutput("post reset in_ready", 32'(in_ready), 32'd1);

    // 256 illegal requests saturate the error counter.
    for (int n = 0; n < 256; n++) begin
      @(negedge clk);
      driveReq(tbl[8], 1'b1);
      @(negedge clk);
      scramble();
      if (n == 0) checkOutput("sat err pulse", 32'(err), 32'd1);
      @(negedge clk);
      if (n == 253) checkOutput("err_cnt 254", 32'(err_cnt), 32'd254);
      if (n == 254) checkOutput("err_cnt 255", 32'(err_cnt), 32'd255);
    end
    checkOutput("err_cnt saturated", 32'(err_cnt), 32'd255);
    checkOutput("sat no write", 32'(imem_addr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, giving the instruction-memory address width; depth is 2**ADDR_W words.
REQ-002 The module SHALL have one clock and asynchronous active-high reset; ports follow.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  request fields valid.
REQ-006 in_ready  output  1  encoder can accept a request this cycle.
REQ-007 op_type  input  2  operation class: 00 ALU, 01 ALU-immediate, 10 memory, 11 branch.
REQ-008 op_code  input  4  operation within class; bit3=1 means vector (class 00 only).
REQ-009 rd, rs1, rs2  input  4 each  destination and source register indices.
REQ-010 imm  input  18  immediate or branch offset.
REQ-011 clear  input  1  synchronous restart.
REQ-012 imem_we  output  1  instruction-memory write strobe.
REQ-013 imem_addr  output  ADDR_W  write address.
REQ-014 imem_wdata  output  32  encoded instruction word.
REQ-015 err  output  1  one-cycle pulse on an illegal request.
REQ-016 err_cnt  output  8  count of illegal requests, saturating at 255.
REQ-017 full  output  1  memory image complete; no further requests are accepted.

Function
REQ-018 The encoding SHALL be [31:30]=op_type, [29:26]=op_code, [25:22]=rd, and [21:18]=rs1.
REQ-019 For op_type 00/10, [17:14] SHALL be rs2 and [13:0] SHALL be 0.
REQ-020 For op_type 01/11, [17:0] SHALL be imm and rs2 SHALL be ignored.
REQ-021 Legal op_code values SHALL be:
  - class 00: 0000-0101 and 1000-1101;
  - class 01: 0000-0101;
  - class 10: 0000-0011;
  - class 11: 0000-0011.
  All other values are illegal.
REQ-022 The FSM states SHALL be IDLE, ENC, WRITE and FULL.
REQ-023 in_ready SHALL be 1 only in IDLE.
REQ-024 In IDLE, in_valid=1 SHALL capture all fields and move to ENC on the next edge.
REQ-025 In ENC, a legal request SHALL register the encoded word and move to WRITE.
REQ-026 In ENC, an illegal request SHALL pulse err for that cycle, increment err_cnt (saturating), and return to IDLE with no write.
REQ-027 In WRITE, imem_we SHALL be 1 with imem_addr=wr_ptr and imem_wdata=the registered word, for exactly one cycle.
REQ-028 On leaving WRITE, if wr_ptr equals 2**ADDR_W-1 the FSM SHALL go to FULL and hold wr_ptr; otherwise it SHALL increment wr_ptr and go to IDLE.
REQ-029 In FULL, full SHALL be 1 and in_ready SHALL be 0; in_valid SHALL be ignored until clear or rst.
REQ-030 Accept-to-write latency SHALL be 2 cycles; maximum throughput SHALL be one instruction per 3 cycles.
REQ-031 Captured fields SHALL NOT change while in ENC or WRITE, regardless of inputs.
REQ-032 clear=1 in any state SHALL, on the next edge, return to IDLE with wr_ptr=0 and err_cnt=0.
REQ-033 imem_we SHALL be gated off in any cycle where clear=1, so a write in progress is aborted.
REQ-034 rst SHALL take priority over clear.
REQ-035 imem_addr SHALL equal wr_ptr in all states; imem_wdata SHALL hold the last registered word while idle.
REQ-036 rd=0 SHALL be encoded unchanged; suppressing the register write is the decoder's responsibility.

Reset
REQ-037 While rst is high the FSM SHALL be IDLE, independent of clk.
REQ-038 Reset values SHALL be: wr_ptr=0, err_cnt=0, imem_wdata=0, imem_we=0, err=0, full=0, in_ready=1.
REQ-039 Reset asserted in WRITE SHALL drop imem_we immediately.

Verification
REQ-040 op_type=00, op_code=0000, rd=3, rs1=1, rs2=2 -> after 2 cycles imem_we=1, imem_addr=0, imem_wdata=0x00C48000.
REQ-041 op_type=01, op_code=0010, rd=5, rs1=4, imm=7, rs2=9 -> imem_wdata=0x49500007 at imem_addr=1.
REQ-042 op_type=10, op_code=0100 -> err high 1 cycle, err_cnt=1, no imem_we, in_ready back to 1.
REQ-043 ADDR_W=2, four legal requests -> addresses 0..3 written, then full=1 and in_ready=0; a fifth in_valid produces no write; clear -> IDLE, wr_ptr=0, full=0.
REQ-044 rst asserted mid-WRITE -> imem_we=0 asynchronously, all outputs at reset values, in_ready=1 after release.
REQ-045 256 illegal requests -> err_cnt saturates at 255.
